// File: rtl/tx_symbol_sched_if.sv
// Link-layer to TX scheduler beat handshake (valid/ready with K flag and end-of-packet marker).
interface tx_symbol_sched_if;
    logic [7:0] tx_data;
    logic       tx_k;
    logic       tx_last;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, tx_k, tx_last, tx_valid, input tx_ready);
    modport slave  (input tx_data, tx_k, tx_last, tx_valid, output tx_ready);
endinterface

// File: rtl/tx_symbol_sched.sv
// TX lane scheduler ahead of the 8b/10b encoder: forwards link-layer beats, fills gaps with
// logical idle and inserts COM + SKP ordered sets between packets every SKIP_INTERVAL symbols.
module tx_symbol_sched #(
    parameter int SKIP_INTERVAL = 1180,
    parameter int SKP_COUNT     = 3,
    parameter int CNT_W         = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_en,
    tx_symbol_sched_if.slave tx,
    output logic [7:0]       enc_data,
    output logic             enc_k,
    output logic             enc_valid,
    output logic             skp_active,
    output logic             underrun
);
    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_SKIP   = 2'd2
    } state_t;

    localparam logic [7:0]       SYM_IDLE = 8'h00;
    localparam logic [7:0]       SYM_COM  = 8'hBC;
    localparam logic [7:0]       SYM_SKP  = 8'h1C;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SKIP_INTERVAL - 1);
    localparam logic [2:0]       IDX_LAST = 3'(SKP_COUNT);

    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_skip_cnt, w_skip_cnt_nx;
    logic             r_skip_pending, w_skip_pending_nx;
    logic             r_in_pkt, w_in_pkt_nx;
    logic [2:0]       r_skp_idx, w_skp_idx_nx;
    logic [7:0]       r_enc_data, w_enc_data_nx;
    logic             r_enc_k, w_enc_k_nx;
    logic             r_enc_valid, w_enc_valid_nx;
    logic             r_skp_active, w_skp_active_nx;
    logic             r_underrun, w_underrun_nx;
    logic             w_ready;
    logic             w_accept;

    // Next-state, next-symbol and handshake decode
    always_comb begin
        w_state_nx        = r_state;
        w_skip_cnt_nx     = r_skip_cnt;
        w_skip_pending_nx = r_skip_pending;
        w_in_pkt_nx       = r_in_pkt;
        w_skp_idx_nx      = r_skp_idx;
        w_enc_data_nx     = SYM_IDLE;
        w_enc_k_nx        = 1'b0;
        w_enc_valid_nx    = 1'b0;
        w_skp_active_nx   = 1'b0;
        w_underrun_nx     = 1'b0;
        w_ready           = 1'b0;
        w_accept          = 1'b0;

        case (r_state)
            ST_OFF: begin
                if (tx_en) begin
                    w_state_nx        = ST_ACTIVE;
                    w_skip_cnt_nx     = '0;
                    w_skip_pending_nx = 1'b0;
                end else begin
                    w_state_nx = ST_OFF;
                end
            end
            ST_ACTIVE: begin
                w_ready  = tx_en & ~(r_skip_pending & ~r_in_pkt);
                w_accept = w_ready & tx.tx_valid;
                if (!tx_en) begin
                    w_state_nx  = ST_OFF;
                    w_in_pkt_nx = 1'b0;
                end else if (r_skip_pending && !r_in_pkt) begin
                    // COM goes out in the same cycle ready drops, so the set is 1+SKP_COUNT symbols long
                    w_state_nx        = ST_SKIP;
                    w_skip_cnt_nx     = '0;
                    w_skip_pending_nx = 1'b0;
                    w_skp_idx_nx      = 3'd1;
                    w_enc_data_nx     = SYM_COM;
                    w_enc_k_nx        = 1'b1;
                    w_enc_valid_nx    = 1'b1;
                    w_skp_active_nx   = 1'b1;
                end else begin
                    w_enc_valid_nx = 1'b1;
                    if (w_accept) begin
                        w_enc_data_nx = tx.tx_data;
                        w_enc_k_nx    = tx.tx_k;
                        w_in_pkt_nx   = ~tx.tx_last;
                    end else begin
                        w_underrun_nx = r_in_pkt;
                    end
                    if (r_skip_cnt == CNT_LAST) begin
                        w_skip_pending_nx = 1'b1;
                    end else begin
                        w_skip_cnt_nx = r_skip_cnt + CNT_W'(1);
                    end
                end
            end
            ST_SKIP: begin
                w_enc_data_nx   = SYM_SKP;
                w_enc_k_nx      = 1'b1;
                w_enc_valid_nx  = 1'b1;
                w_skp_active_nx = 1'b1;
                if (r_skp_idx == IDX_LAST) begin
                    w_skp_idx_nx = 3'd0;
                    if (tx_en) begin
                        w_state_nx = ST_ACTIVE;
                    end else begin
                        w_state_nx = ST_OFF;
                    end
                end else begin
                    w_skp_idx_nx = r_skp_idx + 3'd1;
                end
            end
            default: begin
                w_state_nx = ST_OFF;
            end
        endcase
    end

    // State and registered encoder-side outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_OFF;
            r_skip_cnt     <= '0;
            r_skip_pending <= 1'b0;
            r_in_pkt       <= 1'b0;
            r_skp_idx      <= 3'd0;
            r_enc_data     <= 8'h00;
            r_enc_k        <= 1'b0;
            r_enc_valid    <= 1'b0;
            r_skp_active   <= 1'b0;
            r_underrun     <= 1'b0;
        end else begin
            r_state        <= w_state_nx;
            r_skip_cnt     <= w_skip_cnt_nx;
            r_skip_pending <= w_skip_pending_nx;
            r_in_pkt       <= w_in_pkt_nx;
            r_skp_idx      <= w_skp_idx_nx;
            r_enc_data     <= w_enc_data_nx;
            r_enc_k        <= w_enc_k_nx;
            r_enc_valid    <= w_enc_valid_nx;
            r_skp_active   <= w_skp_active_nx;
            r_underrun     <= w_underrun_nx;
        end
    end

    assign tx.tx_ready = w_ready;
    assign enc_data    = r_enc_data;
    assign enc_k       = r_enc_k;
    assign enc_valid   = r_enc_valid;
    assign skp_active  = r_skp_active;
    assign underrun    = r_underrun;
endmodule

// File: tb/tb_tx_symbol_sched.sv
// Self-checking bench for tx_symbol_sched: vector table, directed SKP corner sequences and
// constrained-random traffic against a queue-based symbol-stream model.
module tb_tx_symbol_sched;
    localparam int SI = 8;
    localparam int SC = 3;

    logic       clk;
    logic       reset;
    logic       tx_en;
    logic [7:0] enc_data;
    logic       enc_k;
    logic       enc_valid;
    logic       skp_active;
    logic       underrun;

    tx_symbol_sched_if bus ();

    tx_symbol_sched #(.SKIP_INTERVAL(SI), .SKP_COUNT(SC), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_en      (tx_en),
        .tx         (bus),
        .enc_data   (enc_data),
        .enc_k      (enc_k),
        .enc_valid  (enc_valid),
        .skp_active (skp_active),
        .underrun   (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // model: lane on/off, symbols emitted since last ordered set, open packet, queued SKP symbols
    bit          m_on;
    int          m_emit;
    bit          m_open;
    logic [7:0]  m_q[$];
    bit          m_ready;
    logic [11:0] m_nxt;

    logic        obs_ready;
    logic [11:0] obs_out;

    function automatic logic [11:0] pk(input bit v, input bit k, input bit s, input bit u, input logic [7:0] d);
        return {v, k, s, u, d};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h  (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit en, input bit vld, input logic [7:0] d, input bit k, input bit last);
        m_nxt   = 12'h000;
        m_ready = 1'b0;
        if (rst) begin
            m_on = 1'b0; m_emit = 0; m_open = 1'b0; m_q.delete();
        end else if (!m_on) begin
            if (en) begin m_on = 1'b1; m_emit = 0; end
        end else if (m_q.size() != 0) begin
            m_nxt = pk(1'b1, 1'b1, 1'b1, 1'b0, m_q.pop_front());
            if (m_q.size() == 0 && !en) m_on = 1'b0;
        end else if (!en) begin
            m_on = 1'b0; m_open = 1'b0;
        end else if (m_emit >= SI && !m_open) begin
            m_nxt = pk(1'b1, 1'b1, 1'b1, 1'b0, 8'hBC);
            for (int i = 0; i < SC; i++) m_q.push_back(8'h1C);
            m_emit = 0;
        end else begin
            m_ready = 1'b1;
            m_emit++;
            if (vld) begin
                m_nxt  = pk(1'b1, k, 1'b0, 1'b0, d);
                m_open = !last;
            end else begin
                m_nxt = pk(1'b1, 1'b0, 1'b0, m_open, 8'h00);
            end
        end
    endtask

    // one clock: drive at negedge, check ready before the edge and outputs after it
    task automatic step(input bit rst, input bit en, input bit vld, input logic [7:0] d, input bit k, input bit last);
        @(negedge clk);
        reset        = rst;
        tx_en        = en;
        bus.tx_valid = vld;
        bus.tx_data  = d;
        bus.tx_k     = k;
        bus.tx_last  = last;
        model_step(rst, en, vld, d, k, last);
        #1;
        obs_ready = bus.tx_ready;
        if (!rst) check("model_ready", {11'h000, obs_ready}, {11'h000, m_ready});
        @(posedge clk);
        #1;
        obs_out = {enc_valid, enc_k, skp_active, underrun, enc_data};
        check("model_out", obs_out, m_nxt);
    endtask

    task automatic idle_step(input bit en);
        step(1'b0, en, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic reset_enable();
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        idle_step(1'b1);
        check("enable_off_cycle", obs_out, 12'h000);
    endtask

    typedef struct packed {
        logic       rst;
        logic       en;
        logic       vld;
        logic [7:0] d;
        logic       k;
        logic       last;
        logic       chk_rdy;
        logic       rdy;
        logic [11:0] out;
    } vec_t;

    function automatic vec_t mk(input bit rst, input bit en, input bit vld, input logic [7:0] d, input bit k,
                                input bit last, input bit chk_rdy, input bit rdy, input logic [11:0] out);
        vec_t v;
        v.rst = rst; v.en = en; v.vld = vld; v.d = d; v.k = k; v.last = last;
        v.chk_rdy = chk_rdy; v.rdy = rdy; v.out = out;
        return v;
    endfunction

    vec_t tbl[14];

    localparam logic [11:0] O_NONE = 12'h000;
    localparam logic [11:0] O_IDLE = 12'h800;
    localparam logic [11:0] O_UND  = 12'h900;
    localparam logic [11:0] O_COM  = 12'hEBC;
    localparam logic [11:0] O_SKP  = 12'hE1C;

    initial begin
        reset = 1'b1; tx_en = 1'b0;
        bus.tx_valid = 1'b0; bus.tx_data = 8'h00; bus.tx_k = 1'b0; bus.tx_last = 1'b0;
        m_on = 1'b0; m_emit = 0; m_open = 1'b0;

        // reset, idle fill, single open packet with underrun, close, lane disable/re-enable
        tbl[0]  = mk(1, 0, 0, 8'h00, 0, 0, 0, 0, O_NONE);
        tbl[1]  = mk(1, 0, 0, 8'h00, 0, 0, 1, 0, O_NONE);
        tbl[2]  = mk(0, 1, 0, 8'h00, 0, 0, 1, 0, O_NONE);
        tbl[3]  = mk(0, 1, 0, 8'h00, 0, 0, 1, 1, O_IDLE);
        tbl[4]  = mk(0, 1, 0, 8'h00, 0, 0, 1, 1, O_IDLE);
        tbl[5]  = mk(0, 1, 1, 8'hAA, 0, 0, 1, 1, 12'h8AA);
        tbl[6]  = mk(0, 1, 0, 8'h00, 0, 0, 1, 1, O_UND);
        tbl[7]  = mk(0, 1, 0, 8'h00, 0, 0, 1, 1, O_UND);
        tbl[8]  = mk(0, 1, 1, 8'h55, 1, 1, 1, 1, 12'hC55);
        tbl[9]  = mk(0, 1, 0, 8'h00, 0, 0, 1, 1, O_IDLE);
        tbl[10] = mk(0, 0, 0, 8'h00, 0, 0, 1, 0, O_NONE);
        tbl[11] = mk(0, 0, 0, 8'h00, 0, 0, 1, 0, O_NONE);
        tbl[12] = mk(0, 1, 0, 8'h00, 0, 0, 1, 0, O_NONE);
        tbl[13] = mk(0, 1, 0, 8'h00, 0, 0, 1, 1, O_IDLE);

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].vld, tbl[i].d, tbl[i].k, tbl[i].last);
            if (tbl[i].chk_rdy) check($sformatf("tbl%0d_ready", i), {11'h000, obs_ready}, {11'h000, tbl[i].rdy});
            check($sformatf("tbl%0d_out", i), obs_out, tbl[i].out);
        end

        // idle link: 8 idles then COM + 3 SKP, period 12
        reset_enable();
        for (int i = 1; i <= 24; i++) begin
            int pos;
            pos = (i - 1) % 12;
            idle_step(1'b1);
            check($sformatf("idle_skp_out%0d", i), obs_out, (pos < 8) ? O_IDLE : ((pos == 8) ? O_COM : O_SKP));
            check($sformatf("idle_skp_rdy%0d", i), {11'h000, obs_ready}, {11'h000, (pos < 8)});
        end

        // 20-beat packet: no SKP inside, set follows last beat, held next beat waits 4 cycles
        reset_enable();
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b1, 1'b1, 8'(i), 1'b0, (i == 20));
            check($sformatf("pkt_beat%0d", i), obs_out, pk(1'b1, 1'b0, 1'b0, 1'b0, 8'(i)));
            check($sformatf("pkt_rdy%0d", i), {11'h000, obs_ready}, 12'h001);
        end
        for (int j = 0; j < 4; j++) begin
            step(1'b0, 1'b1, 1'b1, 8'h21, 1'b0, 1'b1);
            check($sformatf("pkt_set%0d", j), obs_out, (j == 0) ? O_COM : O_SKP);
            check($sformatf("pkt_set_rdy%0d", j), {11'h000, obs_ready}, 12'h000);
        end
        step(1'b0, 1'b1, 1'b1, 8'h21, 1'b0, 1'b1);
        check("pkt_held_beat", obs_out, 12'h821);
        check("pkt_held_rdy", {11'h000, obs_ready}, 12'h001);

        // tx_en dropped while COM is on the output: set still completes, then lane off
        reset_enable();
        for (int i = 0; i < 8; i++) idle_step(1'b1);
        idle_step(1'b1);
        check("en_drop_com", obs_out, O_COM);
        for (int j = 0; j < 3; j++) begin
            idle_step(1'b0);
            check($sformatf("en_drop_skp%0d", j), obs_out, O_SKP);
        end
        for (int j = 0; j < 2; j++) begin
            idle_step(1'b0);
            check($sformatf("en_drop_off%0d", j), obs_out, O_NONE);
            check($sformatf("en_drop_rdy%0d", j), {11'h000, obs_ready}, 12'h000);
        end

        // reset during 2nd SKP aborts the set; restart counts a fresh interval
        reset_enable();
        for (int i = 0; i < 8; i++) idle_step(1'b1);
        idle_step(1'b1);
        idle_step(1'b1);
        idle_step(1'b1);
        check("rst_mid_skp2", obs_out, O_SKP);
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("rst_mid_abort", obs_out, O_NONE);
        idle_step(1'b1);
        check("rst_restart_off", obs_out, O_NONE);
        for (int i = 0; i < 8; i++) begin
            idle_step(1'b1);
            check($sformatf("rst_restart_idle%0d", i), obs_out, O_IDLE);
        end
        idle_step(1'b1);
        check("rst_restart_com", obs_out, O_COM);

        // random traffic: beats held until accepted, sporadic enable toggles and resets
        begin
            bit         r_en, r_rst, b_vld, b_k, b_last;
            logic [7:0] b_d;
            r_en = 1'b1; b_vld = 1'b0; b_d = 8'h00; b_k = 1'b0; b_last = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                r_rst = ($urandom_range(299) == 0);
                if ($urandom_range(39) == 0) r_en = ~r_en;
                if (!b_vld && $urandom_range(3) != 0) begin
                    b_vld  = 1'b1;
                    b_d    = 8'($urandom);
                    b_k    = ($urandom_range(7) == 0);
                    b_last = ($urandom_range(5) == 0);
                end
                step(r_rst, r_en, b_vld, b_d, b_k, b_last);
                if (r_rst || (b_vld && obs_ready)) b_vld = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tx_symbol_sched.md
Name: tx_symbol_sched

Overview:
- Transmit-side scheduler placed directly in front of the 8b/10b encoder in the PHY TX lane.
- Accepts link-layer symbols over a valid/ready handshake and drives the encoder's 8-bit data and K-flag inputs with exactly one symbol per enabled cycle.
- Fills gaps with logical idle (D0.0).
- Periodically inserts a SKP ordered set (COM followed by SKP_COUNT SKP symbols), but only between packets.

Parameters:
- SKIP_INTERVAL, 1180, number of symbols emitted outside SKIP after which a SKP ordered set becomes pending (must be ≥ 2).
- SKP_COUNT, 3, number of SKP (K28.0) symbols following COM in each ordered set (1..7).
- CNT_W, 11, width of the skip-interval counter; must satisfy 2^CNT_W > SKIP_INTERVAL.

Ports:
- clk  input  1  single clock for the whole block.
- reset  input  1  synchronous, active-high reset.
- tx_en  input  1  lane transmit enable.
- tx_data  input  8  symbol from link layer.
- tx_k  input  1  symbol is a control (K) character.
- tx_last  input  1  beat is the last symbol of a packet.
- tx_valid  input  1  tx_data/tx_k/tx_last are valid.
- tx_ready  output  1  scheduler accepts the beat this cycle (combinational).
- enc_data  output  8  to encoder 8-bit input.
- enc_k  output  1  to encoder dataK input.
- enc_valid  output  1  enc_data/enc_k hold a symbol to be encoded this cycle.
- skp_active  output  1  current enc symbol belongs to a SKP ordered set.
- underrun  output  1  one-cycle pulse when idle is emitted while a packet is open.

Behaviour:
- One clock; reset is synchronous and active-high (ports clk, reset).
- Reset values:
  - Outputs: enc_data=8'h00, enc_k=0, enc_valid=0, skp_active=0, underrun=0.
  - Internal: state=OFF, skip_cnt=0, skip_pending=0, in_pkt=0, skp_idx=0.
  - Reset in any state, including mid-SKIP or mid-packet, aborts immediately; no ordered-set completion.
- States: OFF, ACTIVE, SKIP.
- OFF:
  - enc_valid=0, tx_ready=0.
  - tx_en=1 → ACTIVE next cycle; skip_cnt and skip_pending are cleared on entry.
- ACTIVE:
  - tx_ready = tx_en & ~(skip_pending & ~in_pkt).
  - Accepted beat (tx_valid & tx_ready): next cycle enc_data=tx_data, enc_k=tx_k, enc_valid=1. Latency is exactly 1 cycle.
  - in_pkt is set on any accepted beat with tx_last=0 and cleared on an accepted beat with tx_last=1. A single-beat packet (tx_last=1 on first beat) leaves in_pkt=0.
  - No accepted beat: next cycle emit idle (enc_data=8'h00, enc_k=0, enc_valid=1). If in_pkt=1, also pulse underrun for that same cycle.
  - skip_cnt increments on each emitted symbol.
  - When skip_cnt reaches SKIP_INTERVAL-1 while emitting, skip_pending←1 and skip_cnt holds (saturates).
  - skip_pending & ~in_pkt & tx_en → SKIP. The transition occurs in the same cycle that ready is low, so no beat is lost.
  - tx_en=0 → OFF at the next cycle boundary. in_pkt is cleared and enc_valid=0 from the following cycle.
- SKIP:
  - Emits COM (8'hBC, k=1), then SKP_COUNT × SKP (8'h1C, k=1), one per cycle, with skp_active=1 on each.
  - tx_ready=0 throughout. skp_idx counts 0..SKP_COUNT.
  - On entry, skip_cnt←0 and skip_pending←0.
  - After the last SKP: → ACTIVE, or → OFF if tx_en=0. tx_en deassertion during SKIP is deferred until the ordered set completes.
  - skip_cnt does not count SKIP symbols.
- Simultaneous events:
  - The packet-closing beat (tx_last) in the same cycle skip_pending sets: the beat is accepted, and SKIP starts the following cycle.
  - tx_valid is ignored while tx_ready=0. The link layer must hold the beat stable until it is accepted.
- Ordering of enc_valid symbols is strictly: accepted data in acceptance order, with idles/SKP sets inserted between them.

Test Plan:
1. Reset, tx_en=1, no tx_valid → cycle after ACTIVE entry, enc_valid=1 with enc_data=8'h00, enc_k=0 every cycle; underrun never pulses.
2. SKIP_INTERVAL=8, SKP_COUNT=3, idle link → after 8 idles, sequence BC/k1, 1C/k1 ×3 with skp_active=1, then idles; repeats every 12 cycles.
3. SKIP_INTERVAL=8, 20-beat packet 8'h01..8'h14 with tx_valid continuous → no SKP inside packet. SKP set immediately follows beat 8'h14; tx_ready low for 4 cycles; all 20 bytes appear in order, 1-cycle latency.
4. Packet open (one beat 8'hAA, tx_last=0), then tx_valid=0 for 2 cycles → two idles with underrun=1 on each; tx_last beat closes in_pkt.
5. tx_en dropped during the COM cycle of SKIP → all 3 SKP symbols still emitted, then enc_valid=0 and tx_ready=0.
6. reset asserted during the 2nd SKP symbol → next cycle all outputs at reset values; tx_en=1 again restarts with skip_cnt=0 (first SKP after exactly SKIP_INTERVAL idles).
